// File: rtl/uart_pkg.sv
// Shared UART/DTM definitions: framing bytes, command and address encodings,
// decoder states and the per-address write-length lookup.
package uart_pkg;

  localparam logic [7:0] HEADER = 8'h01;
  localparam logic [7:0] ESC    = 8'hA0;
  localparam int MAX_STB        = 6;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'b000,
    CMD_READ      = 3'b001,
    CMD_CONT_READ = 3'b010,
    CMD_WRITE     = 3'b011,
    CMD_RESET     = 3'b111
  } cmd_e;

  typedef enum logic [4:0] {
    ADDR_IDCODE  = 5'h01,
    ADDR_DTMCS   = 5'h10,
    ADDR_DMI     = 5'h11,
    ADDR_STB0_CS = 5'h14,
    ADDR_STB0_D  = 5'h15
  } addr_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_ESC,
    ST_ISSUE
  } frame_state_e;

  // Strobe channel k owns the CS/D register pair starting at 5'h14.
  function automatic logic [4:0] stb_addr(input int k, input logic is_data);
    return 5'(20 + 2 * k + (is_data ? 1 : 0));
  endfunction

  function automatic int get_write_length(input logic [4:0] addr, input int num_stb,
                                          input int stb_dwidth);
    int len;
    len = 8;
    case (addr)
      ADDR_IDCODE, ADDR_DTMCS: len = 32;
      ADDR_DMI:                len = 41;
      default: begin
        // CS registers and unmapped addresses keep the 8-bit default.
        for (int k = 0; k < MAX_STB; k++) begin
          if (k < num_stb && addr == stb_addr(k, 1'b1)) len = stb_dwidth;
        end
      end
    endcase
    return len;
  endfunction

  function automatic logic esc_literal_ok(input logic [7:0] b);
    return (b == HEADER) || (b == ESC);
  endfunction

endpackage

// File: rtl/dtm_esc_filter.sv
// Byte-stream unstuffer: passes bytes through unchanged and classifies each one
// relative to the escape context supplied by the frame FSM.
module dtm_esc_filter (
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       esc_pending,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       is_esc,
  output logic       is_literal,
  output logic       is_header,
  output logic       bad_esc
);
  import uart_pkg::*;

  assign out_data   = in_data;
  assign out_valid  = in_valid;
  assign in_ready   = out_ready;

  assign is_esc     = !esc_pending && (in_data == ESC);
  assign is_header  = !esc_pending && (in_data == HEADER);
  assign is_literal = esc_pending && esc_literal_ok(in_data);
  assign bad_esc    = esc_pending && !esc_literal_ok(in_data);

endmodule

// File: rtl/dtm_frame_decoder.sv
// Receive-side DTM frame decoder: parses HEADER-framed commands, unstuffs ESC
// sequences and presents one decoded command per frame on a valid/ready port.
module dtm_frame_decoder #(
  parameter int MAX_WLEN   = 64,
  parameter int NUM_STB    = 2,
  parameter int STB_DWIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    rx_data_i,
  input  logic                          rx_valid_i,
  output logic                          rx_ready_o,
  output logic                          cmd_valid_o,
  input  logic                          cmd_ready_i,
  output logic [2:0]                    cmd_o,
  output logic [4:0]                    addr_o,
  output logic [MAX_WLEN-1:0]           wdata_o,
  output logic [$clog2(MAX_WLEN+1)-1:0] wlen_o,
  output logic                          cont_read_o,
  output logic                          err_o
);
  import uart_pkg::*;

  localparam int LW     = $clog2(MAX_WLEN + 1);
  localparam int NBYTES = (MAX_WLEN + 7) / 8;
  localparam int BCW    = $clog2(NBYTES + 1);

  if (MAX_WLEN < 41) begin : g_chk_wlen
    $error("dtm_frame_decoder: MAX_WLEN must be at least 41");
  end
  if (MAX_WLEN < STB_DWIDTH) begin : g_chk_stb_width
    $error("dtm_frame_decoder: STB_DWIDTH must not exceed MAX_WLEN");
  end
  if (NUM_STB < 1 || NUM_STB > 6) begin : g_chk_num_stb
    $error("dtm_frame_decoder: NUM_STB must be in 1..6");
  end

  frame_state_e        state;
  logic [BCW-1:0]      byte_cnt;
  logic [BCW-1:0]      byte_last;
  logic [MAX_WLEN-1:0] wmask;

  logic [7:0] f_data;
  logic       f_valid, f_ready;
  logic       f_is_esc, f_is_lit, f_is_hdr, f_bad;

  dtm_esc_filter u_esc_filter (
    .in_data     (rx_data_i),
    .in_valid    (rx_valid_i),
    .in_ready    (f_ready),
    .esc_pending (state == ST_ESC),
    .out_data    (f_data),
    .out_valid   (f_valid),
    .out_ready   (rx_ready_o),
    .is_esc      (f_is_esc),
    .is_literal  (f_is_lit),
    .is_header   (f_is_hdr),
    .bad_esc     (f_bad)
  );

  logic                byte_acc;
  logic [2:0]          rx_cmd;
  logic [4:0]          rx_addr;
  int                  lk_len;
  logic [MAX_WLEN-1:0] lk_mask;
  logic [MAX_WLEN-1:0] byte_word;
  logic                store_byte;

  assign byte_acc  = f_valid && f_ready;
  assign rx_cmd    = f_data[7:5];
  assign rx_addr   = f_data[4:0];
  assign byte_word = {{(MAX_WLEN-8){1'b0}}, f_data} << {byte_cnt, 3'b000};
  assign store_byte = byte_acc &&
                      (((state == ST_DATA) && !f_is_esc && !f_is_hdr) ||
                       ((state == ST_ESC) && f_is_lit));

  // Length and bit mask of the write payload addressed by the current cmd byte.
  always_comb begin
    lk_len  = get_write_length(rx_addr, NUM_STB, STB_DWIDTH);
    lk_mask = '0;
    for (int i = 0; i < MAX_WLEN; i++) lk_mask[i] = (i < lk_len);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rx_ready_o  <= 1'b1;
      cmd_valid_o <= 1'b0;
      cmd_o       <= '0;
      addr_o      <= '0;
      wdata_o     <= '0;
      wlen_o      <= '0;
      cont_read_o <= 1'b0;
      err_o       <= 1'b0;
      byte_cnt    <= '0;
      byte_last   <= '0;
      wmask       <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (byte_acc && f_is_hdr) begin
            state       <= ST_CMD;
            wdata_o     <= '0;
            cont_read_o <= 1'b0;
          end
        end
        ST_CMD: begin
          if (byte_acc) begin
            if (f_is_hdr) begin
              wdata_o <= '0;
            end else begin
              cmd_o  <= rx_cmd;
              addr_o <= rx_addr;
              case (rx_cmd)
                CMD_NOP: state <= ST_IDLE;
                CMD_READ, CMD_CONT_READ, CMD_RESET: begin
                  state       <= ST_ISSUE;
                  wlen_o      <= '0;
                  cmd_valid_o <= 1'b1;
                  rx_ready_o  <= 1'b0;
                end
                CMD_WRITE: begin
                  state     <= ST_DATA;
                  wlen_o    <= LW'(lk_len);
                  wmask     <= lk_mask;
                  byte_cnt  <= '0;
                  byte_last <= BCW'((lk_len + 7) / 8 - 1);
                end
                default: begin
                  err_o <= 1'b1;
                  state <= ST_IDLE;
                end
              endcase
            end
          end
        end
        ST_DATA: begin
          if (byte_acc && f_is_esc) begin
            state <= ST_ESC;
          end else if (byte_acc && f_is_hdr) begin
            // An unescaped HEADER aborts the payload and opens a new frame.
            err_o       <= 1'b1;
            state       <= ST_CMD;
            wdata_o     <= '0;
            cont_read_o <= 1'b0;
          end
        end
        ST_ESC: begin
          if (byte_acc && f_bad) begin
            err_o <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready_i) begin
            state       <= ST_IDLE;
            cmd_valid_o <= 1'b0;
            rx_ready_o  <= 1'b1;
            if (cmd_o == CMD_CONT_READ) cont_read_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (store_byte) begin
        wdata_o <= wdata_o | (byte_word & wmask);
        if (byte_cnt == byte_last) begin
          state       <= ST_ISSUE;
          cmd_valid_o <= 1'b1;
          rx_ready_o  <= 1'b0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
          state    <= ST_DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_dtm_frame_decoder.sv
// Directed bench for dtm_frame_decoder: a default instance and a wide-strobe
// instance (NUM_STB=4, STB_DWIDTH=64) share stimulus, selected by 'sel'.
module tb_dtm_frame_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_ready = 1'b0;

  logic        rdy_a, cv_a, cr_a, err_a, rdy_b, cv_b, cr_b, err_b;
  logic [2:0]  cmd_a, cmd_b;
  logic [4:0]  addr_a, addr_b;
  logic [63:0] wdata_a, wdata_b;
  logic [6:0]  wlen_a, wlen_b;

  logic        rdy, cv, cr, err;
  logic [2:0]  cmd;
  logic [4:0]  addr;
  logic [63:0] wdata;
  logic [6:0]  wlen;

  int checks = 0;
  int passes = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  dtm_frame_decoder dut_a (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid & ~sel),
    .rx_ready_o(rdy_a), .cmd_valid_o(cv_a), .cmd_ready_i(cmd_ready & ~sel),
    .cmd_o(cmd_a), .addr_o(addr_a), .wdata_o(wdata_a), .wlen_o(wlen_a),
    .cont_read_o(cr_a), .err_o(err_a)
  );

  dtm_frame_decoder #(.MAX_WLEN(64), .NUM_STB(4), .STB_DWIDTH(64)) dut_b (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid & sel),
    .rx_ready_o(rdy_b), .cmd_valid_o(cv_b), .cmd_ready_i(cmd_ready & sel),
    .cmd_o(cmd_b), .addr_o(addr_b), .wdata_o(wdata_b), .wlen_o(wlen_b),
    .cont_read_o(cr_b), .err_o(err_b)
  );

  assign rdy   = sel ? rdy_b   : rdy_a;
  assign cv    = sel ? cv_b    : cv_a;
  assign cr    = sel ? cr_b    : cr_a;
  assign err   = sel ? err_b   : err_a;
  assign cmd   = sel ? cmd_b   : cmd_a;
  assign addr  = sel ? addr_b  : addr_a;
  assign wdata = sel ? wdata_b : wdata_a;
  assign wlen  = sel ? wlen_b  : wlen_a;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Offers one byte and returns #1 after the clock edge that accepted it.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      $error("[TB] FAIL rx_timeout: observed rx_ready=0 expected rx_ready=1 for byte %h", b);
    end else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic sendBytes();
    for (int i = 0; i < txq.size(); i++) applyStimulus(txq[i]);
  endtask

  task automatic handshake(input string tag);
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    checkOutput({tag, "_hs_valid"}, 64'(cv), 64'd0);
    checkOutput({tag, "_hs_ready"}, 64'(rdy), 64'd1);
  endtask

  task automatic checkCmd(input string tag, input logic [2:0] c, input logic [4:0] a,
                          input logic [63:0] d, input logic [6:0] l);
    checkOutput({tag, "_valid"}, 64'(cv), 64'd1);
    checkOutput({tag, "_rxrdy"}, 64'(rdy), 64'd0);
    checkOutput({tag, "_cmd"}, 64'(cmd), 64'(c));
    checkOutput({tag, "_addr"}, 64'(addr), 64'(a));
    checkOutput({tag, "_wdata"}, wdata, d);
    checkOutput({tag, "_wlen"}, 64'(wlen), 64'(l));
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rxrdy"}, 64'(rdy), 64'd1);
    checkOutput({tag, "_valid"}, 64'(cv), 64'd0);
    checkOutput({tag, "_cmd"}, 64'(cmd), 64'd0);
    checkOutput({tag, "_addr"}, 64'(addr), 64'd0);
    checkOutput({tag, "_wdata"}, wdata, 64'd0);
    checkOutput({tag, "_wlen"}, 64'(wlen), 64'd0);
    checkOutput({tag, "_cont"}, 64'(cr), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkReset("rst_a");
    sel = 1'b1; #1;
    checkReset("rst_b");
    sel = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain 32-bit DTMCS write.
    txq = {8'h01, 8'h70, 8'h78, 8'h56, 8'h34};
    sendBytes();
    checkOutput("wr_early_valid", 64'(cv), 64'd0);
    applyStimulus(8'h12);
    checkCmd("wr_dtmcs", 3'd3, 5'h10, 64'h1234_5678, 7'd32);
    handshake("wr_dtmcs");

    // READ issues the cycle after the command byte.
    applyStimulus(8'h01);
    checkOutput("rd_after_hdr_valid", 64'(cv), 64'd0);
    applyStimulus(8'h31);
    checkCmd("rd_dmi", 3'd1, 5'h11, 64'd0, 7'd0);
    handshake("rd_dmi");

    // Escaped HEADER and ESC literals inside a STB0_D payload.
    txq = {8'h01, 8'h75, 8'hA0, 8'h01, 8'hA0, 8'hA0, 8'h02, 8'h03};
    sendBytes();
    checkCmd("wr_esc", 3'd3, 5'h15, 64'h0302_A001, 7'd32);
    handshake("wr_esc");

    // Unescaped HEADER aborts the write and starts a new frame.
    txq = {8'h01, 8'h70, 8'hAA, 8'h01};
    sendBytes();
    checkOutput("abort_err", 64'(err), 64'd1);
    checkOutput("abort_valid", 64'(cv), 64'd0);
    applyStimulus(8'h31);
    checkCmd("abort_rd", 3'd1, 5'h11, 64'd0, 7'd0);
    handshake("abort_rd");

    // Continuous read, cleared by the next HEADER; NOP issues nothing.
    txq = {8'h01, 8'h54};
    sendBytes();
    checkCmd("cont_rd", 3'd2, 5'h14, 64'd0, 7'd0);
    handshake("cont_rd");
    checkOutput("cont_set", 64'(cr), 64'd1);
    applyStimulus(8'h01);
    checkOutput("cont_clear", 64'(cr), 64'd0);
    applyStimulus(8'h00);
    checkOutput("nop_valid", 64'(cv), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("nop_valid_late", 64'(cv), 64'd0);
    checkOutput("nop_rxrdy", 64'(rdy), 64'd1);

    // 41-bit DMI write: bits above the length are masked off.
    txq = {8'h01, 8'h71, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    sendBytes();
    checkCmd("wr_dmi", 3'd3, 5'h11, 64'h1FF_FFFF_FFFF, 7'd41);
    handshake("wr_dmi");

    // Strobe channel 2 does not exist with NUM_STB=2, so its length is 8.
    txq = {8'h01, 8'h79, 8'hFF};
    sendBytes();
    checkCmd("wr_unmapped", 3'd3, 5'h19, 64'hFF, 7'd8);
    handshake("wr_unmapped");

    // Undefined command code.
    txq = {8'h01, 8'h80};
    sendBytes();
    checkOutput("undef_err", 64'(err), 64'd1);
    checkOutput("undef_valid", 64'(cv), 64'd0);
    @(posedge clk); #1;
    checkOutput("undef_err_pulse", 64'(err), 64'd0);

    // Bad escape drops to IDLE; the following frame still decodes.
    txq = {8'h01, 8'h70, 8'hA0, 8'h55};
    sendBytes();
    checkOutput("badesc_err", 64'(err), 64'd1);
    txq = {8'h01, 8'hE1};
    sendBytes();
    checkCmd("reset_cmd", 3'd7, 5'h01, 64'd0, 7'd0);
    handshake("reset_cmd");

    // Wide-strobe instance: 64-bit STB3_D write held by backpressure.
    sel = 1'b1; #1;
    txq = {8'h01, 8'h7B, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    sendBytes();
    checkCmd("wr_stb3", 3'd3, 5'h1B, 64'h8877_6655_4433_2211, 7'd64);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_rxrdy", 64'(rdy), 64'd0);
      checkOutput("hold_valid", 64'(cv), 64'd1);
      checkOutput("hold_wdata", wdata, 64'h8877_6655_4433_2211);
      checkOutput("hold_wlen", 64'(wlen), 64'd64);
    end
    rx_valid = 1'b0;
    handshake("wr_stb3");

    // Reset mid-payload drops the partial frame.
    txq = {8'h01, 8'h7B, 8'h11, 8'h22, 8'h33};
    sendBytes();
    rst = 1'b1;
    #1;
    checkReset("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_no_cmd", 64'(cv), 64'd0);
    txq = {8'h01, 8'h31};
    sendBytes();
    checkCmd("post_rst_rd", 3'd1, 5'h11, 64'd0, 7'd0);
    handshake("post_rst_rd");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
